// File: rtl/aq_djpeg_pixwr.sv
// aq_djpeg_pixwr
//   Packs the decoder's scattered block-order pixel stream into 32-bit XRGB
//   words, computes each pixel's linear frame-buffer byte address, and
//   presents {address, data} pairs as a valid/ready write-request stream
//   through a 16-entry first-word-fall-through FIFO. The decoder cannot be
//   stalled, so a push into a full FIFO is dropped and flagged.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ProcessInit       decoder idle: flush pipeline/FIFO and re-arm counters
//   BaseAddr          frame-buffer byte base address
//   InWidth/InHeight  image size in pixels
//   InEnable          pixel valid; InPixelX/InPixelY position; InR/InG/InB colour
//   WrValid/WrReady   write-request handshake
//   WrAddr/WrData     byte address and {8'h00, R, G, B}
//   Overflow          sticky: a pixel was dropped on a full FIFO
//   PixelCount        accepted write handshakes since last init (saturating)
//   FrameDone         one-cycle pulse when PixelCount reaches width*height
module aq_djpeg_pixwr #(
    parameter int FIFO_AW        = 4,
    parameter int PIX_BYTES_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ProcessInit,
    input  logic [31:0] BaseAddr,
    input  logic [15:0] InWidth,
    input  logic [15:0] InHeight,
    input  logic        InEnable,
    input  logic [15:0] InPixelX,
    input  logic [15:0] InPixelY,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    output logic        WrValid,
    input  logic        WrReady,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        Overflow,
    output logic [31:0] PixelCount,
    output logic        FrameDone
);

    localparam int DEPTH = 1 << FIFO_AW;
    // The output register holds the head entry, so the backing memory only
    // ever needs DEPTH-1 slots for a total occupancy of DEPTH.
    localparam logic [FIFO_AW:0] MEM_FULL = (FIFO_AW + 1)'(DEPTH - 1);

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic flush;
    assign flush = rst | ProcessInit;

    // ---- Stage p0: capture pixel ----
    logic        vld_p0;
    logic [15:0] pixX_p0;
    logic [15:0] pixY_p0;
    logic [23:0] rgb_p0;

    always_ff @(posedge clk) begin
        if (flush) vld_p0 <= 1'b0;
        else       vld_p0 <= InEnable;
    end

    always_ff @(posedge clk) begin
        if (InEnable) begin
            pixX_p0 <= InPixelX;
            pixY_p0 <= InPixelY;
            rgb_p0  <= {InR, InG, InB};
        end
    end

    // ---- Stage p1: row offset product ----
    logic        vld_p1;
    logic [31:0] prod_p1;
    logic [15:0] pixX_p1;
    logic [23:0] rgb_p1;

    always_ff @(posedge clk) begin
        if (flush) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        prod_p1 <= {16'd0, pixY_p0} * {16'd0, InWidth};
        pixX_p1 <= pixX_p0;
        rgb_p1  <= rgb_p0;
    end

    // ---- Stage p2: byte address, FIFO push (address wraps silently) ----
    logic [31:0] addr_p2;
    logic [63:0] entry_p2;

    assign addr_p2  = BaseAddr + ((prod_p1 + {16'd0, pixX_p1}) << PIX_BYTES_LOG2);
    assign entry_p2 = {addr_p2, 8'h00, rgb_p1};

    logic [63:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic [FIFO_AW:0]   memCount;

    logic pop, full, push, loadOut, fromMem, bypass, toMem;

    assign pop     = WrValid & WrReady;
    assign full    = WrValid && (memCount == MEM_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign push    = vld_p1 && (!full || pop);
    assign loadOut = pop || !WrValid;
    assign fromMem = loadOut && (memCount != '0);
    // Empty FIFO: the new entry goes straight into the output register.
    assign bypass  = loadOut && (memCount == '0) && push;
    assign toMem   = push && !bypass;

    always_ff @(posedge clk) begin
        if (flush) begin
            WrValid  <= 1'b0;
            memCount <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (toMem)   wrPtr <= wrPtr + 1'b1;
            if (fromMem) rdPtr <= rdPtr + 1'b1;
            memCount <= memCount + {{FIFO_AW{1'b0}}, toMem} - {{FIFO_AW{1'b0}}, fromMem};
            if (loadOut) WrValid <= fromMem | bypass;
            if (vld_p1 && full && !pop) Overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (toMem) mem[wrPtr] <= entry_p2;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            WrAddr <= '0;
            WrData <= '0;
        end else if (fromMem) begin
            {WrAddr, WrData} <= mem[rdPtr];
        end else if (bypass) begin
            {WrAddr, WrData} <= entry_p2;
        end
    end

    // Pixel counting and frame completion
    logic [31:0] targetPix;
    logic [31:0] nextCount;
    logic        doneFired;

    assign nextCount = satInc(PixelCount);

    always_ff @(posedge clk) begin
        targetPix <= {16'd0, InWidth} * {16'd0, InHeight};
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            PixelCount <= '0;
            FrameDone  <= 1'b0;
            doneFired  <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            if (pop) begin
                PixelCount <= nextCount;
                if (nextCount == targetPix && targetPix != '0 && !doneFired) begin
                    FrameDone <= 1'b1;
                    doneFired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_pixwr.sv
// Directed bench for aq_djpeg_pixwr: stimulus pushes expected {addr, data}
// words into a scoreboard queue; a negedge monitor pops and compares on
// every write handshake.
module tb_aq_djpeg_pixwr;

    logic        clk = 1'b0;
    logic        rst;
    logic        ProcessInit;
    logic [31:0] BaseAddr;
    logic [15:0] InWidth;
    logic [15:0] InHeight;
    logic        InEnable;
    logic [15:0] InPixelX;
    logic [15:0] InPixelY;
    logic [7:0]  InR;
    logic [7:0]  InG;
    logic [7:0]  InB;
    logic        WrValid;
    logic        WrReady;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic        Overflow;
    logic [31:0] PixelCount;
    logic        FrameDone;

    always #5 clk = ~clk;

    aq_djpeg_pixwr #(.FIFO_AW(4), .PIX_BYTES_LOG2(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ProcessInit(ProcessInit),
        .BaseAddr   (BaseAddr),
        .InWidth    (InWidth),
        .InHeight   (InHeight),
        .InEnable   (InEnable),
        .InPixelX   (InPixelX),
        .InPixelY   (InPixelY),
        .InR        (InR),
        .InG        (InG),
        .InB        (InB),
        .WrValid    (WrValid),
        .WrReady    (WrReady),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .Overflow   (Overflow),
        .PixelCount (PixelCount),
        .FrameDone  (FrameDone)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sbq[$];
    logic [63:0] expE;
    int          fdPulses = 0;
    logic [31:0] fdCount = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && !ProcessInit && WrValid && WrReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h, expected no write", WrAddr, WrData);
            end else begin
                expE = sbq.pop_front();
                chk("wr_addr", WrAddr, expE[63:32]);
                chk("wr_data", WrData, expE[31:0]);
            end
        end
        if (!rst && FrameDone) begin
            fdPulses++;
            fdCount = PixelCount;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPix(input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [31:0] expAddr, input bit drop);
        InEnable = 1'b1;
        InPixelX = x;
        InPixelY = y;
        InR = r;
        InG = g;
        InB = b;
        if (!drop) sbq.push_back({expAddr, 8'h00, r, g, b});
        tick();
        InEnable = 1'b0;
    endtask

    task automatic initPulse();
        ProcessInit = 1'b1;
        sbq.delete();
        tick();
        ProcessInit = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) tick();
        tick();
        chk("drain_left", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ProcessInit = 1'b1;
        InEnable = 1'b0;
        WrReady = 1'b0;
        BaseAddr = 32'd0;
        InWidth = 16'd0;
        InHeight = 16'd0;
        InPixelX = 16'd0;
        InPixelY = 16'd0;
        InR = 8'd0;
        InG = 8'd0;
        InB = 8'd0;
        repeat (3) tick();

        chk("rst_wrvalid",  32'(WrValid), 32'd0);
        chk("rst_wraddr",   WrAddr, 32'd0);
        chk("rst_wrdata",   WrData, 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        chk("rst_pixcount", PixelCount, 32'd0);
        chk("rst_framedone", 32'(FrameDone), 32'd0);

        // Single pixel
        rst = 1'b0;
        BaseAddr = 32'h1000_0000;
        InWidth = 16'd640;
        InHeight = 16'd480;
        tick();
        ProcessInit = 1'b0;
        WrReady = 1'b1;
        sendPix(16'd3, 16'd2, 8'h11, 8'h22, 8'h33, 32'h1000_140C, 1'b0);
        chk("lat_n1_valid", 32'(WrValid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(WrValid), 32'd0);
        tick();
        chk("lat_n3_valid", 32'(WrValid), 32'd1);
        tick();
        chk("single_pixcount", PixelCount, 32'd1);
        chk("single_empty", 32'(WrValid), 32'd0);

        // Stall: 16 entries fill the FIFO, the 17th is dropped
        WrReady = 1'b0;
        BaseAddr = 32'h3000_0000;
        for (int i = 0; i < 16; i++)
            sendPix(16'(i), 16'd1, 8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i),
                    32'h3000_0A00 + 32'(4 * i), 1'b0);
        repeat (3) tick();
        chk("stall_valid", 32'(WrValid), 32'd1);
        chk("stall_ovf", 32'(Overflow), 32'd0);
        chk("stall_addr", WrAddr, 32'h3000_0A00);
        chk("stall_data", WrData, 32'h00A0_B0C0);
        repeat (4) tick();
        chk("stall_addr_hold", WrAddr, 32'h3000_0A00);
        sendPix(16'd16, 16'd1, 8'hEE, 8'hEE, 8'hEE, 32'd0, 1'b1);
        repeat (3) tick();
        chk("stall_ovf_set", 32'(Overflow), 32'd1);
        WrReady = 1'b1;
        drain(40);
        chk("stall_drained", 32'(WrValid), 32'd0);
        chk("stall_pixcount", PixelCount, 32'd17);

        // Full FIFO with a simultaneous pop
        BaseAddr = 32'h4000_0000;
        InWidth = 16'd16;
        WrReady = 1'b0;
        initPulse();
        chk("init_ovf_clear", 32'(Overflow), 32'd0);
        for (int i = 0; i < 17; i++)
            sendPix(16'(i), 16'd0, 8'(i), 8'(i), 8'(i), 32'h4000_0000 + 32'(4 * i), 1'b0);
        tick();
        WrReady = 1'b1;
        tick();
        WrReady = 1'b0;
        chk("fullpop_ovf", 32'(Overflow), 32'd0);
        chk("fullpop_head", WrAddr, 32'h4000_0004);
        sendPix(16'd17, 16'd0, 8'h77, 8'h77, 8'h77, 32'd0, 1'b1);
        repeat (3) tick();
        chk("fullpop_still_full", 32'(Overflow), 32'd1);
        WrReady = 1'b1;
        drain(40);
        chk("fullpop_pixcount", PixelCount, 32'd17);

        // Frame completion on an 8x8 image
        BaseAddr = 32'h2000_0000;
        InWidth = 16'd8;
        InHeight = 16'd8;
        initPulse();
        WrReady = 1'b1;
        fdPulses = 0;
        for (int i = 0; i < 64; i++)
            sendPix(16'(i % 8), 16'(i / 8), 8'(i), 8'(~i), 8'h5A,
                    32'h2000_0000 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 4; i++)
            sendPix(16'(i), 16'd8, 8'h01, 8'h02, 8'h03,
                    32'h2000_0000 + 32'(4 * (64 + i)), 1'b0);
        drain(20);
        repeat (3) tick();
        chk("frame_pulses", 32'(fdPulses), 32'd1);
        chk("frame_count_at_pulse", fdCount, 32'd64);
        chk("frame_pixcount", PixelCount, 32'd68);

        // Address wrap-around
        BaseAddr = 32'hFFFF_FFF0;
        initPulse();
        sendPix(16'd5, 16'd0, 8'h01, 8'h02, 8'h03, 32'h0000_0004, 1'b0);
        drain(10);
        chk("wrap_ovf", 32'(Overflow), 32'd0);
        chk("wrap_pixcount", PixelCount, 32'd1);

        // Mid-frame init discards queued pixels and ignores a same-cycle handshake
        BaseAddr = 32'h5000_0000;
        InWidth = 16'd100;
        InHeight = 16'd100;
        initPulse();
        WrReady = 1'b0;
        for (int i = 0; i < 10; i++)
            sendPix(16'(i), 16'd0, 8'h10, 8'h20, 8'(i), 32'h5000_0000 + 32'(4 * i), 1'b0);
        repeat (3) tick();
        chk("mid_queued", 32'(WrValid), 32'd1);
        ProcessInit = 1'b1;
        WrReady = 1'b1;
        sbq.delete();
        tick();
        ProcessInit = 1'b0;
        WrReady = 1'b0;
        chk("mid_valid", 32'(WrValid), 32'd0);
        chk("mid_pixcount", PixelCount, 32'd0);
        chk("mid_ovf", 32'(Overflow), 32'd0);
        repeat (4) tick();
        chk("mid_stay_empty", 32'(WrValid), 32'd0);
        WrReady = 1'b1;
        sendPix(16'd7, 16'd3, 8'hDE, 8'hAD, 8'hBE, 32'h5000_04CC, 1'b0);
        drain(10);
        chk("mid_next_pixcount", PixelCount, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_pixwr.md
Name: aq_djpeg_pixwr

Overview:
- Sits directly downstream of the aq_djpeg top decoder.
- Takes its scattered block-order pixel stream (enable, X, Y, R, G, B, image width/height) and packs each pixel into a 32-bit XRGB word.
- Computes the linear frame-buffer byte address for each pixel.
- Buffers address/data pairs in a FIFO and presents them as a valid/ready memory-write request stream; it also counts written pixels and flags frame completion.
- The decoder has no output backpressure, so this block detects and flags FIFO overflow.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth = 16 entries)
- PIX_BYTES_LOG2, 2, log2 bytes per pixel; fixed 4-byte XRGB words

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ProcessInit  in  1  decoder idle flag; high = flush and re-arm
- BaseAddr  in  32  frame-buffer byte base address; must be quasi-static while ProcessInit is low
- InWidth  in  16  image width in pixels
- InHeight  in  16  image height in pixels
- InEnable  in  1  pixel valid, one pixel per cycle max
- InPixelX  in  16  pixel column
- InPixelY  in  16  pixel row
- InR  in  8  red
- InG  in  8  green
- InB  in  8  blue
- WrValid  out  1  write request valid
- WrReady  in  1  write request accepted this cycle when WrValid & WrReady
- WrAddr  out  32  byte address
- WrData  out  32  {8'h00, R, G, B}
- Overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- PixelCount  out  32  number of accepted write handshakes since last init
- FrameDone  out  1  single-cycle pulse when PixelCount reaches InWidth*InHeight

Behaviour:
- Reset (rst=1) values:
  - WrValid=0, WrAddr=0, WrData=0, Overflow=0, PixelCount=0, FrameDone=0.
  - FIFO empty; all pipeline valid bits 0.
- Reset takes effect at the next edge, including mid-frame. All in-flight pixels are discarded.
- ProcessInit=1 has the same effect as rst on the FIFO, pipeline, Overflow, PixelCount and FrameDone. A Wr handshake in that cycle is ignored.
- Pipeline, 3 stages. Input regs are loaded on InEnable.
  - S1: register X, Y, RGB, valid.
  - S2: Prod = Y * InWidth. Unsigned 16x16 -> 32 bits, registered; X, RGB, valid carried.
  - S3: Addr = BaseAddr + ((Prod + X) << PIX_BYTES_LOG2). Truncated to 32 bits; wrap-around is silent. The entry {Addr, 00RRGGBB} is pushed to the FIFO.
- Latency:
  - InEnable in cycle N -> FIFO write at the edge ending cycle N+2.
  - If the FIFO was empty, WrValid=1 in cycle N+3 with that entry on WrAddr/WrData (first-word-fall-through, registered outputs).
- Throughput: 1 pixel/cycle sustained when WrReady is held 1.
- Handshake rules:
  - The FIFO head is popped when WrValid & WrReady.
  - WrAddr/WrData are stable while WrValid=1 and WrReady=0.
  - WrValid drops only after a pop leaves the FIFO empty.
- FIFO full/empty:
  - Push when full with no pop in the same cycle: the entry is dropped and Overflow is set (sticky until rst/ProcessInit).
  - Push when full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Pop when empty is impossible, because WrValid=0.
- No pixel filtering: out-of-range X/Y are written as computed. Upstream already masks them.
- PixelCount increments by 1 per handshake; saturates at 32'hFFFFFFFF.
- FrameDone:
  - Pulses in the cycle after the handshake that makes PixelCount == InWidth*InHeight (32-bit product, registered).
  - Fires once per init. Further handshakes do not re-fire it.
  - Width or height = 0: FrameDone never fires.

Test Plan:
- Single pixel: rst then ProcessInit 1->0, BaseAddr=0x1000_0000, InWidth=640. Drive InEnable with X=3, Y=2, RGB=11/22/33, WrReady=1.
  - Expect WrValid 3 cycles later, WrAddr=0x1000_140C, WrData=0x00112233.
  - Expect PixelCount=1 after the handshake.
- Stall: WrReady=0 while 16 consecutive pixels are pushed.
  - Expect the FIFO full, Overflow=0, WrAddr/WrData frozen on pixel 0.
  - A 17th pixel sets Overflow=1. Releasing WrReady drains exactly 16 entries, in order.
- Full plus simultaneous pop: FIFO at 16 entries, WrReady=1 in the same cycle a new entry reaches S3.
  - Expect no drop, Overflow stays 0, occupancy stays 16.
- Frame completion: 8x8 image, 64 pixels streamed with WrReady=1.
  - Expect a one-cycle FrameDone pulse after handshake 64, PixelCount=64, and no second pulse on extra pixels.
- Address wrap: BaseAddr=0xFFFF_FFF0, X=5, Y=0.
  - Expect WrAddr=0x0000_0004 with no error flag.
- Mid-frame init: 10 pixels queued with WrReady=0, then ProcessInit=1 for 1 cycle.
  - Expect WrValid=0 next cycle, PixelCount=0, Overflow=0; the following pixel is handled normally.
